// File: rtl/adxl_spi_interface.sv
// Bit-level SPI mode-3 engine for the ADXL345: shifts a 16-bit command word out
// MSB-first, captures MISO, and returns the last received byte with a done pulse.
module adxl_spi_interface #(
    parameter int unsigned CLK_DIV    = 50,  // clk cycles per SCLK half-period, 2..255
    parameter int unsigned FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  transmit,
    input  logic [FRAME_BITS-1:0] txdata,
    input  logic                  sdi,
    output logic                  sdo,
    output logic                  sclk,
    output logic                  ss,
    output logic [7:0]            rxdata,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_FINISH
    } state_e;

    state_e                state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [7:0]            rx_shift_q, rx_shift_d;
    logic [7:0]            rxdata_q,   rxdata_d;
    logic                  sclk_q,     sclk_d;
    logic                  ss_q,       ss_d;
    logic                  sdo_q,      sdo_d;
    logic                  done_q,     done_d;
    logic                  busy_q,     busy_d;
    logic                  cnt_wrap;

    assign cnt_wrap = (cnt_q == CNT_MAX);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rxdata_d   = rxdata_q;
        sclk_d     = sclk_q;
        ss_d       = ss_q;
        sdo_d      = sdo_q;
        done_d     = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                ss_d   = 1'b1;
                sclk_d = 1'b1;
                sdo_d  = 1'b0;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (transmit) begin
                    tx_shift_d = txdata;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    ss_d       = 1'b0;
                    sdo_d      = txdata[FRAME_BITS-1];
                    busy_d     = 1'b1;
                    state_d    = S_SETUP;
                end
            end

            S_SETUP: begin
                if (cnt_wrap) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SHIFT: begin
                if (cnt_wrap) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // Falling edge: present the current MSB; the slave samples it on the next rise.
                        sclk_d = 1'b0;
                        sdo_d  = tx_shift_q[FRAME_BITS-1];
                    end else begin
                        sclk_d     = 1'b1;
                        rx_shift_d = {rx_shift_q[6:0], sdi};
                        tx_shift_d = tx_shift_q << 1;
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_HOLD;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_HOLD: begin
                if (cnt_wrap) begin
                    cnt_d   = '0;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_FINISH: begin
                ss_d     = 1'b1;
                rxdata_d = rx_shift_q;
                done_d   = 1'b1;
                busy_d   = 1'b1;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Reset forces the bus idle at once, aborting any frame without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rxdata_q   <= '0;
            sclk_q     <= 1'b1;
            ss_q       <= 1'b1;
            sdo_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rxdata_q   <= rxdata_d;
            sclk_q     <= sclk_d;
            ss_q       <= ss_d;
            sdo_q      <= sdo_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign sdo    = sdo_q;
    assign sclk   = sclk_q;
    assign ss     = ss_q;
    assign rxdata = rxdata_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_adxl_spi_interface.sv
// Self-checking bench for adxl_spi_interface: a slave model drives MISO on falling SCLK
// and frame timing, MOSI bits and returned bytes are checked against plain arithmetic.
module tb_adxl_spi_interface;

    localparam int DIV_A = 50;
    localparam int DIV_B = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        transmit;
    logic [15:0] txdata;
    logic        sdi;
    logic        sel;

    logic        tr_a, tr_b;
    logic        a_sdo, a_sclk, a_ss, a_done, a_busy;
    logic        b_sdo, b_sclk, b_ss, b_done, b_busy;
    logic [7:0]  a_rxdata, b_rxdata;
    logic        obs_sdo, obs_sclk, obs_ss, obs_done, obs_busy;
    logic [7:0]  obs_rxdata;

    int          n_cmp;
    int          n_bad;
    logic [7:0]  last_rx [2];

    always #5 clk = ~clk;

    assign tr_a = transmit & ~sel;
    assign tr_b = transmit & sel;

    adxl_spi_interface #(.CLK_DIV(DIV_A), .FRAME_BITS(16)) u_dut_a (
        .clk(clk), .rst(rst), .transmit(tr_a), .txdata(txdata), .sdi(sdi),
        .sdo(a_sdo), .sclk(a_sclk), .ss(a_ss), .rxdata(a_rxdata), .done(a_done), .busy(a_busy)
    );

    adxl_spi_interface #(.CLK_DIV(DIV_B), .FRAME_BITS(16)) u_dut_b (
        .clk(clk), .rst(rst), .transmit(tr_b), .txdata(txdata), .sdi(sdi),
        .sdo(b_sdo), .sclk(b_sclk), .ss(b_ss), .rxdata(b_rxdata), .done(b_done), .busy(b_busy)
    );

    assign obs_sdo    = sel ? b_sdo    : a_sdo;
    assign obs_sclk   = sel ? b_sclk   : a_sclk;
    assign obs_ss     = sel ? b_ss     : a_ss;
    assign obs_done   = sel ? b_done   : a_done;
    assign obs_busy   = sel ? b_busy   : a_busy;
    assign obs_rxdata = sel ? b_rxdata : a_rxdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame on the selected DUT. The slave returns rbyte in the last 8 bit slots;
    // junk=1 puts random bits in the first 8 slots. preset=1 means transmit/txdata are
    // already driven; chain=1 launches next_tx in the done cycle and returns there.
    task automatic run_frame(input logic [15:0] tx, input logic [7:0] rbyte, input bit junk,
                             input int hold, input int intrude, input bit preset,
                             input bit chain, input logic [15:0] next_tx);
        int         d, limit, falls, rises, done_cyc, n_done, ss_bad, busy_bad, tail_bad;
        int         rise1, rise2;
        logic [15:0] sdo_word;
        logic        prev_sclk, busy_at_done, ss_at_done;
        logic [7:0]  rx_at_done;
        d = sel ? DIV_B : DIV_A;
        limit = 34 * d + 1 + (chain ? 0 : 3 * d + 4);
        falls = 0; rises = 0; done_cyc = -1; n_done = 0;
        ss_bad = 0; busy_bad = 0; tail_bad = 0; rise1 = 0; rise2 = 0;
        sdo_word = '0; prev_sclk = 1'b1; busy_at_done = 1'b0; ss_at_done = 1'b0; rx_at_done = 'x;
        if (!preset) begin
            check("rx_hold", obs_rxdata, last_rx[sel]);
            txdata   = tx;
            transmit = 1'b1;
        end
        @(posedge clk);
        for (int cyc = 0; cyc <= limit; cyc++) begin
            if (cyc > 0) @(posedge clk);
            @(negedge clk);
            if (cyc == hold - 1) transmit = 1'b0;
            if (intrude > 0 && cyc == intrude) begin
                transmit = 1'b1;
                txdata   = 16'hB500;
            end
            if (intrude > 0 && cyc == intrude + 1) transmit = 1'b0;
            if (prev_sclk && !obs_sclk) begin
                falls++;
                if (falls >= 9 && falls <= 16) sdi = rbyte[16 - falls];
                else sdi = junk ? 1'($urandom) : 1'b0;
            end
            if (!prev_sclk && obs_sclk) begin
                rises++;
                if (rises <= 16) sdo_word = {sdo_word[14:0], obs_sdo};
                if (rises == 1) rise1 = cyc;
                if (rises == 2) rise2 = cyc;
            end
            prev_sclk = obs_sclk;
            if (n_done == 0 && obs_ss !== 1'b0 && !obs_done) ss_bad++;
            if (n_done == 0 && obs_busy !== 1'b1) busy_bad++;
            if (n_done > 0 && cyc > done_cyc &&
                (obs_busy !== 1'b0 || obs_ss !== 1'b1 || obs_sclk !== 1'b1 || obs_sdo !== 1'b0))
                tail_bad++;
            if (obs_done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    done_cyc     = cyc;
                    rx_at_done   = obs_rxdata;
                    busy_at_done = obs_busy;
                    ss_at_done   = obs_ss;
                    if (chain) begin
                        txdata   = next_tx;
                        transmit = 1'b1;
                        break;
                    end
                end
            end
        end
        check("done_cycle",   done_cyc, 34 * d + 1);
        check("done_count",   n_done, 1);
        check("sdo_bits",     sdo_word, tx);
        check("rise_count",   rises, 16);
        check("ss_low",       ss_bad, 0);
        check("busy_frame",   busy_bad, 0);
        check("busy_at_done", busy_at_done, 1'b1);
        check("ss_at_done",   ss_at_done, 1'b1);
        check("rxdata",       rx_at_done, rbyte);
        check("sclk_period",  rise2 - rise1, 2 * d);
        if (!chain) check("idle_after", tail_bad, 0);
        last_rx[sel] = rbyte;
    endtask

    initial begin
        int         edges, bad;
        logic       prev;
        logic [7:0] r;
        n_cmp = 0; n_bad = 0;
        last_rx[0] = 8'h00; last_rx[1] = 8'h00;
        rst = 1'b0; transmit = 1'b0; txdata = '0; sdi = 1'b0; sel = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_ss",     a_ss, 1'b1);
        check("reset_sclk",   a_sclk, 1'b1);
        check("reset_sdo",    a_sdo, 1'b0);
        check("reset_busy",   a_busy, 1'b0);
        check("reset_done",   a_done, 1'b0);
        check("reset_rxdata", a_rxdata, 8'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Write POWER_CTL with transmit held two cycles, MISO low.
        run_frame(16'h2D08, 8'h00, 1'b0, 2, 0, 1'b0, 1'b0, 16'h0000);
        // Read Y low byte.
        run_frame(16'hB400, 8'hA5, 1'b1, 1, 0, 1'b0, 1'b0, 16'h0000);
        // Request mid-frame is ignored.
        r = 8'($urandom);
        run_frame(16'hB400, r, 1'b1, 1, 20 * DIV_A, 1'b0, 1'b0, 16'h0000);

        // Asynchronous reset at the 8th sclk edge.
        txdata = 16'hB400; transmit = 1'b1;
        @(posedge clk);
        @(negedge clk);
        transmit = 1'b0;
        edges = 0; prev = 1'b1;
        for (int i = 0; i < 40 * DIV_A && edges < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_sclk !== prev) begin
                edges++;
                prev = a_sclk;
            end
        end
        check("rst_edge8_reached", edges, 8);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_ss",     a_ss, 1'b1);
        check("rst_mid_sclk",   a_sclk, 1'b1);
        check("rst_mid_sdo",    a_sdo, 1'b0);
        check("rst_mid_busy",   a_busy, 1'b0);
        check("rst_mid_rxdata", a_rxdata, 8'h00);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_done !== 1'b0) bad++;
        end
        rst = 1'b1;
        repeat (3 * DIV_A) begin
            @(negedge clk);
            if (a_done !== 1'b0 || a_ss !== 1'b1) bad++;
        end
        check("rst_no_done", bad, 0);
        last_rx[0] = 8'h00; last_rx[1] = 8'h00;
        r = 8'($urandom);
        run_frame(16'hB200, r, 1'b1, 1, 0, 1'b0, 1'b0, 16'h0000);

        // Back-to-back: second request issued in the done cycle.
        r = 8'($urandom);
        run_frame(16'hB400, r, 1'b1, 1, 0, 1'b0, 1'b1, 16'hB500);
        run_frame(16'hB500, 8'h03, 1'b1, 1, 0, 1'b1, 1'b0, 16'h0000);

        repeat (2) run_frame(16'($urandom), 8'($urandom), 1'b1, 1, 0, 1'b0, 1'b0, 16'h0000);

        // CLK_DIV=2 instance.
        sel = 1'b1;
        @(negedge clk);
        run_frame(16'hB400, 8'h5C, 1'b1, 1, 0, 1'b0, 1'b0, 16'h0000);
        repeat (12) run_frame(16'($urandom), 8'($urandom), 1'b1, 1, 0, 1'b0, 1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
